// File: rtl/mmu_sram_pkg.sv
// Shared constants for the memory access unit: request op encodings,
// exception codes and op classification helpers.
package mmu_sram_pkg;

  localparam int MEM_OPT_WIDTH  = 3;
  localparam int EXC_CODE_WIDTH = 5;

  localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_NONE = 3'd0;
  localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LW   = 3'd1;
  localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LB   = 3'd2;
  localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LBU  = 3'd3;
  localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_SW   = 3'd4;
  localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_SB   = 3'd5;

  localparam logic [EXC_CODE_WIDTH-1:0] EC_NONE = 5'd0;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_ADEL = 5'd4;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_ADES = 5'd5;

  function automatic logic op_is_load(input logic [MEM_OPT_WIDTH-1:0] op);
    return (op == MEM_OPT_LW) || (op == MEM_OPT_LB) || (op == MEM_OPT_LBU);
  endfunction

  function automatic logic op_is_store(input logic [MEM_OPT_WIDTH-1:0] op);
    return (op == MEM_OPT_SW) || (op == MEM_OPT_SB);
  endfunction

endpackage

// File: rtl/mmu_addr_check.sv
// Combinational virtual-to-physical translation (fixed kseg map) plus
// segment, range and alignment checking for one memory request.
module mmu_addr_check
  import mmu_sram_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 20
) (
  input  logic [31:0]                vaddr,
  input  logic [MEM_OPT_WIDTH-1:0]   op,
  output logic [RAM_ADDR_WIDTH-1:0]  word_addr,
  output logic [EXC_CODE_WIDTH-1:0]  exc_code
);

  logic [31:0] phys;
  logic        seg_err;
  logic        range_err;
  logic        align_err;

  always_comb begin
    phys    = vaddr;
    seg_err = 1'b0;
    if (vaddr[31]) begin
      // kseg0/kseg1 fold onto the low 512 MB; kseg2/3 are not mapped here
      if (vaddr[30]) seg_err = 1'b1;
      else           phys    = {3'b000, vaddr[28:0]};
    end
  end

  assign range_err = |phys[31:RAM_ADDR_WIDTH+2];
  assign align_err = ((op == MEM_OPT_LW) || (op == MEM_OPT_SW)) && (phys[1:0] != 2'b00);
  assign word_addr = phys[RAM_ADDR_WIDTH+1:2];

  always_comb begin
    exc_code = EC_NONE;
    if (seg_err || range_err || align_err) begin
      if (op_is_load(op))       exc_code = EC_ADEL;
      else if (op_is_store(op)) exc_code = EC_ADES;
    end
  end

endmodule

// File: rtl/mmu_sram.sv
// Memory access unit: accepts one load/store per request, checks the address,
// and drives a 32-bit asynchronous SRAM with SRAM_WAIT-cycle strobes.
module mmu_sram
  import mmu_sram_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 20,
  parameter int SRAM_WAIT      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [MEM_OPT_WIDTH-1:0]   opt,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata,
  output logic [EXC_CODE_WIDTH-1:0]  exc_code,
  output logic                       busy,
  output logic [RAM_ADDR_WIDTH-1:0]  ram_addr,
  output logic [31:0]                ram_wdata,
  input  logic [31:0]                ram_rdata,
  output logic                       ram_ce_n,
  output logic                       ram_oe_n,
  output logic                       ram_we_n
);

  localparam int              CNT_W    = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SRAM_WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_TURN, S_WR} state_t;

  state_t                      state, state_next;
  logic [CNT_W-1:0]            cnt, cnt_next;
  logic                        busy_next;
  logic [31:0]                 rdata_next;
  logic [EXC_CODE_WIDTH-1:0]   exc_next;
  logic [RAM_ADDR_WIDTH-1:0]   addr_next;
  logic [31:0]                 wdata_next;
  logic                        ce_next, oe_next, we_next;
  logic                        accept;

  logic [RAM_ADDR_WIDTH-1:0]   chk_addr;
  logic [EXC_CODE_WIDTH-1:0]   chk_exc;

  logic [MEM_OPT_WIDTH-1:0]    req_op;
  logic [1:0]                  req_lane;
  logic [7:0]                  req_byte;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [MEM_OPT_WIDTH-1:0] op,
                                              input logic [1:0] lane);
    logic signed [7:0]  lane_byte;
    logic signed [31:0] ext;
    lane_byte = word[{lane, 3'b000} +: 8];
    ext       = lane_byte;
    if (op == MEM_OPT_LW)      return word;
    else if (op == MEM_OPT_LB) return ext;
    else                       return {24'h000000, lane_byte};
  endfunction

  function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                             input logic [7:0]  new_byte,
                                             input logic [1:0]  lane);
    logic [31:0] merged;
    merged = word;
    merged[{lane, 3'b000} +: 8] = new_byte;
    return merged;
  endfunction

  mmu_addr_check #(
    .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH)
  ) u_addr_check (
    .vaddr     (addr),
    .op        (opt),
    .word_addr (chk_addr),
    .exc_code  (chk_exc)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    busy_next  = busy;
    rdata_next = rdata;
    exc_next   = EC_NONE;
    addr_next  = ram_addr;
    wdata_next = ram_wdata;
    ce_next    = ram_ce_n;
    oe_next    = ram_oe_n;
    we_next    = ram_we_n;
    accept     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (op_is_load(opt) || op_is_store(opt)) begin
          if (chk_exc != EC_NONE) begin
            exc_next = chk_exc;
          end else begin
            accept    = 1'b1;
            busy_next = 1'b1;
            cnt_next  = CNT_LOAD;
            addr_next = chk_addr;
            ce_next   = 1'b0;
            if (opt == MEM_OPT_SW) begin
              state_next = S_WR;
              wdata_next = wdata;
              we_next    = 1'b0;
            end else begin
              state_next = S_RD;
              oe_next    = 1'b0;
            end
          end
        end
      end
      S_RD: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          ce_next = 1'b1;
          oe_next = 1'b1;
          if (req_op == MEM_OPT_SB) begin
            wdata_next = merge_byte(ram_rdata, req_byte, req_lane);
            state_next = S_TURN;
          end else begin
            rdata_next = load_extend(ram_rdata, req_op, req_lane);
            busy_next  = 1'b0;
            state_next = S_IDLE;
          end
        end
      end
      // Strobes stay high here so the SRAM releases the bus before we drive it
      S_TURN: begin
        state_next = S_WR;
        cnt_next   = CNT_LOAD;
        ce_next    = 1'b0;
        we_next    = 1'b0;
      end
      S_WR: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          ce_next    = 1'b1;
          we_next    = 1'b1;
          busy_next  = 1'b0;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      rdata     <= '0;
      exc_code  <= EC_NONE;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_ce_n  <= 1'b1;
      ram_oe_n  <= 1'b1;
      ram_we_n  <= 1'b1;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      busy      <= busy_next;
      rdata     <= rdata_next;
      exc_code  <= exc_next;
      ram_addr  <= addr_next;
      ram_wdata <= wdata_next;
      ram_ce_n  <= ce_next;
      ram_oe_n  <= oe_next;
      ram_we_n  <= we_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_op   <= opt;
      req_lane <= addr[1:0];
      req_byte <= wdata[7:0];
    end
  end

  // Requests are only legal while idle; anything presented while busy is dropped
  protocol_idle_only: assert property (@(posedge clk) disable iff (!rst)
    !(busy && (opt != MEM_OPT_NONE)))
    else $warning("mmu_sram: request presented while busy was ignored");

endmodule

// File: tb/tb_mmu_sram.sv
// Bench for mmu_sram: SRAM device model, directed scenarios and randomized
// traffic against an address-map/memory reference model.
module tb_mmu_sram;
  import mmu_sram_pkg::*;

  localparam int RAW  = 20;
  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  opt;
  logic [31:0] addr, wdata, rdata, ram_wdata, ram_rdata;
  logic [4:0]  exc_code;
  logic        busy, ram_ce_n, ram_oe_n, ram_we_n;
  logic [RAW-1:0] ram_addr;

  logic        pl_en;
  logic [11:0] pl_idx;
  logic [31:0] pl_val;
  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic [11:0] sram_idx;

  int passed = 0;
  int total  = 0;

  int          nb, nr, nw, nt;
  logic [4:0]  ef, ea;
  logic        cf, ca;
  logic [RAW-1:0] af;

  always #5 clk = ~clk;

  mmu_sram #(.RAM_ADDR_WIDTH(RAW), .SRAM_WAIT(WAIT)) dut (
    .clk(clk), .rst(rst), .opt(opt), .addr(addr), .wdata(wdata),
    .rdata(rdata), .exc_code(exc_code), .busy(busy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  // SRAM device: asynchronous read, write captured while ce/we are low
  assign sram_idx  = 12'(ram_addr % 20'd4096);
  assign ram_rdata = (!ram_ce_n && !ram_oe_n) ? mem[sram_idx] : 32'h0;
  always @(posedge clk) begin
    if (!ram_ce_n && !ram_we_n) mem[sram_idx] <= ram_wdata;
    else if (pl_en)             mem[pl_idx]   <= pl_val;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", passed, total);
    $fatal(1);
  end

  task automatic preload(input int idx, input logic [31:0] v);
    pl_en = 1'b1; pl_idx = idx[11:0]; pl_val = v;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[idx] = v;
  endtask

  // Issues one request from a negedge and observes it until busy drops
  task automatic access(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    opt = op; addr = a; wdata = wd;
    @(negedge clk);
    opt = MEM_OPT_NONE; addr = $urandom; wdata = $urandom;
    ef = exc_code; cf = ram_ce_n; af = ram_addr;
    nb = 0; nr = 0; nw = 0; nt = 0;
    while (busy && nb < 64) begin
      if (!ram_ce_n && !ram_oe_n) nr++;
      if (!ram_ce_n && !ram_we_n) nw++;
      if (ram_ce_n && ram_oe_n && ram_we_n) nt++;
      nb++;
      @(negedge clk);
    end
    ea = exc_code; ca = ram_ce_n;
    if (nb == 0) begin
      @(negedge clk);
      ea = exc_code; ca = ram_ce_n;
    end
  endtask

  // Reference address map: kuseg identity, kseg0/1 fold to low 512 MB
  function automatic void predict(input logic [2:0] op, input logic [31:0] va,
                                  output logic err, output logic [31:0] phys);
    err  = 1'b0;
    phys = va;
    if (va >= 32'hC000_0000)      err  = 1'b1;
    else if (va >= 32'h8000_0000) phys = va & 32'h1FFF_FFFF;
    if (phys >= (32'd4 << RAW)) err = 1'b1;
    if ((op == MEM_OPT_LW || op == MEM_OPT_SW) && (va % 4 != 0)) err = 1'b1;
  endfunction

  task automatic test_reset;
    total++; if (rdata !== 32'h0) $display("FAIL rst_rdata: got %h expected %h", rdata, 32'h0); else passed++;
    total++; if (exc_code !== EC_NONE) $display("FAIL rst_exc: got %0d expected %0d", exc_code, EC_NONE); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passed++;
    total++; if (ram_addr !== '0) $display("FAIL rst_ram_addr: got %h expected 0", ram_addr); else passed++;
    total++; if (ram_wdata !== 32'h0) $display("FAIL rst_ram_wdata: got %h expected 0", ram_wdata); else passed++;
    total++; if ({ram_ce_n, ram_oe_n, ram_we_n} !== 3'b111)
      $display("FAIL rst_strobes: got %b expected 111", {ram_ce_n, ram_oe_n, ram_we_n}); else passed++;
  endtask

  task automatic test_loads;
    access(MEM_OPT_LW, 32'h8000_0010, 32'h0);
    total++; if (af !== RAW'(4)) $display("FAIL lw_ram_addr: got %h expected %h", af, 4); else passed++;
    total++; if (nb !== WAIT) $display("FAIL lw_busy_cycles: got %0d expected %0d", nb, WAIT); else passed++;
    total++; if (nr !== WAIT) $display("FAIL lw_read_strobe: got %0d expected %0d", nr, WAIT); else passed++;
    total++; if (rdata !== 32'hDEAD_BEEF) $display("FAIL lw_rdata: got %h expected %h", rdata, 32'hDEAD_BEEF); else passed++;
    access(MEM_OPT_LB, 32'h8000_0013, 32'h0);
    total++; if (rdata !== 32'hFFFF_FFDE) $display("FAIL lb_rdata: got %h expected %h", rdata, 32'hFFFF_FFDE); else passed++;
    access(MEM_OPT_LBU, 32'hA000_0013, 32'h0);
    total++; if (rdata !== 32'h0000_00DE) $display("FAIL lbu_rdata: got %h expected %h", rdata, 32'h0000_00DE); else passed++;
  endtask

  task automatic test_sb_rmw;
    access(MEM_OPT_SB, 32'h8000_0011, 32'h0000_0055);
    ref_mem[4] = 32'hDEAD_55EF;
    total++; if (nb !== 2*WAIT+1) $display("FAIL sb_busy_cycles: got %0d expected %0d", nb, 2*WAIT+1); else passed++;
    total++; if (nr !== WAIT) $display("FAIL sb_read_strobe: got %0d expected %0d", nr, WAIT); else passed++;
    total++; if (nw !== WAIT) $display("FAIL sb_write_strobe: got %0d expected %0d", nw, WAIT); else passed++;
    total++; if (nt !== 1) $display("FAIL sb_turn_cycles: got %0d expected 1", nt); else passed++;
    total++; if (mem[4] !== 32'hDEAD_55EF) $display("FAIL sb_mem_word: got %h expected %h", mem[4], 32'hDEAD_55EF); else passed++;
    total++; if (rdata !== 32'h0000_00DE) $display("FAIL sb_rdata_held: got %h expected %h", rdata, 32'h0000_00DE); else passed++;
  endtask

  task automatic test_errors;
    access(MEM_OPT_LW, 32'h8000_0002, 32'h0);
    total++; if (ef !== EC_ADEL) $display("FAIL lw_misalign_exc: got %0d expected %0d", ef, EC_ADEL); else passed++;
    total++; if (ea !== EC_NONE) $display("FAIL lw_misalign_exc_1cyc: got %0d expected %0d", ea, EC_NONE); else passed++;
    total++; if (nb !== 0) $display("FAIL lw_misalign_busy: got %0d expected 0", nb); else passed++;
    total++; if ({cf, ca} !== 2'b11) $display("FAIL lw_misalign_ce: got %b expected 11", {cf, ca}); else passed++;
    access(MEM_OPT_SW, 32'hC000_0000, 32'h1234_5678);
    total++; if (ef !== EC_ADES) $display("FAIL sw_kseg3_exc: got %0d expected %0d", ef, EC_ADES); else passed++;
    total++; if (ea !== EC_NONE) $display("FAIL sw_kseg3_exc_1cyc: got %0d expected %0d", ea, EC_NONE); else passed++;
  endtask

  task automatic test_range;
    access(MEM_OPT_LW, 32'h8040_0000, 32'h0);
    total++; if (ef !== EC_ADEL) $display("FAIL range_over_exc: got %0d expected %0d", ef, EC_ADEL); else passed++;
    access(MEM_OPT_LW, 32'h803F_FFFC, 32'h0);
    total++; if (af !== RAW'(20'hFFFFF)) $display("FAIL range_top_addr: got %h expected %h", af, 20'hFFFFF); else passed++;
    total++; if (ef !== EC_NONE) $display("FAIL range_top_exc: got %0d expected %0d", ef, EC_NONE); else passed++;
    total++; if (rdata !== ref_mem[4095]) $display("FAIL range_top_rdata: got %h expected %h", rdata, ref_mem[4095]); else passed++;
  endtask

  task automatic test_back_to_back_random;
    logic [2:0]  ops [5] = '{MEM_OPT_LW, MEM_OPT_LB, MEM_OPT_LBU, MEM_OPT_SW, MEM_OPT_SB};
    logic [31:0] exp_rdata;
    exp_rdata = rdata;
    for (int i = 0; i < 80; i++) begin
      logic [2:0]  op;
      logic [31:0] base, va, phys, wd, word, b;
      int          cls, w, lane, idx, exp_lat;
      logic        err;
      logic [4:0]  exp_exc;
      op   = ops[$urandom % 5];
      cls  = $urandom % 8;
      w    = $urandom % 256;
      lane = $urandom % 4;
      wd   = $urandom;
      case (cls)
        3:       base = 32'hA000_0000;
        4:       base = 32'h0000_0000;
        6:       base = 32'hC000_0000;
        7:       base = 32'h8040_0000;
        default: base = 32'h8000_0000;
      endcase
      if (cls <= 4 && (op == MEM_OPT_LW || op == MEM_OPT_SW)) lane = 0;
      if (cls == 5) lane = 1 + ($urandom % 3);
      va = base + w * 4 + lane;
      predict(op, va, err, phys);
      idx     = (phys / 4) % 4096;
      exp_lat = err ? 0 : ((op == MEM_OPT_SB) ? 2*WAIT+1 : WAIT);
      exp_exc = !err ? EC_NONE : ((op == MEM_OPT_SW || op == MEM_OPT_SB) ? EC_ADES : EC_ADEL);
      if (!err) begin
        word = ref_mem[idx];
        b    = (word >> (8 * (va % 4))) & 32'hFF;
        case (op)
          MEM_OPT_LW:  exp_rdata = word;
          MEM_OPT_LB:  exp_rdata = (b >= 128) ? b - 32'd256 : b;
          MEM_OPT_LBU: exp_rdata = b;
          MEM_OPT_SW:  ref_mem[idx] = wd;
          default:     ref_mem[idx] = (word & ~(32'hFF << (8 * (va % 4)))) | ((wd & 32'hFF) << (8 * (va % 4)));
        endcase
      end
      access(op, va, wd);
      total++; if (nb !== exp_lat) $display("FAIL rnd%0d_latency op=%0d va=%h: got %0d expected %0d", i, op, va, nb, exp_lat); else passed++;
      total++; if (ef !== exp_exc) $display("FAIL rnd%0d_exc op=%0d va=%h: got %0d expected %0d", i, op, va, ef, exp_exc); else passed++;
      total++; if (rdata !== exp_rdata) $display("FAIL rnd%0d_rdata op=%0d va=%h: got %h expected %h", i, op, va, rdata, exp_rdata); else passed++;
      if (!err) begin
        total++; if (af !== RAW'(phys / 4)) $display("FAIL rnd%0d_ram_addr va=%h: got %h expected %h", i, va, af, phys / 4); else passed++;
        if (op == MEM_OPT_SW || op == MEM_OPT_SB) begin
          total++; if (mem[idx] !== ref_mem[idx]) $display("FAIL rnd%0d_mem va=%h: got %h expected %h", i, va, mem[idx], ref_mem[idx]); else passed++;
        end
      end
    end
  endtask

  task automatic test_async_reset;
    int          n;
    logic [31:0] old_word, new_word;
    old_word = ref_mem[8];
    new_word = {old_word[31:8], 8'hAB};
    opt = MEM_OPT_SB; addr = 32'h8000_0020; wdata = 32'h0000_00AB;
    @(negedge clk);
    opt = MEM_OPT_NONE;
    n = 0;
    while (ram_we_n && n < 16) begin
      @(negedge clk);
      n++;
    end
    total++; if (ram_we_n !== 1'b0) $display("FAIL arst_reach_wr: we_n got %b expected 0 within 16 cycles", ram_we_n); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if (ram_we_n !== 1'b1) $display("FAIL arst_we_n: got %b expected 1", ram_we_n); else passed++;
    total++; if (ram_ce_n !== 1'b1) $display("FAIL arst_ce_n: got %b expected 1", ram_ce_n); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b expected 0", busy); else passed++;
    total++; if (rdata !== 32'h0) $display("FAIL arst_rdata: got %h expected 0", rdata); else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (mem[8] !== old_word && mem[8] !== new_word)
      $display("FAIL arst_partial_sb: got %h expected %h or %h", mem[8], old_word, new_word); else passed++;
    access(MEM_OPT_LW, 32'h8000_0010, 32'h0);
    total++; if (nb !== WAIT) $display("FAIL arst_lw_latency: got %0d expected %0d", nb, WAIT); else passed++;
    total++; if (rdata !== ref_mem[4]) $display("FAIL arst_lw_rdata: got %h expected %h", rdata, ref_mem[4]); else passed++;
  endtask

  initial begin
    rst = 1'b0; opt = MEM_OPT_NONE; addr = 32'h0; wdata = 32'h0;
    pl_en = 1'b0; pl_idx = 12'h0; pl_val = 32'h0;
    repeat (2) @(negedge clk);
    test_reset;
    for (int i = 0; i < 256; i++) preload(i, $urandom);
    preload(4095, $urandom);
    preload(4, 32'hDEAD_BEEF);
    rst = 1'b1;
    @(negedge clk);
    test_loads;
    test_sb_rmw;
    test_errors;
    test_range;
    test_back_to_back_random;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
